adder_chunked: RTL and testbench

ADDER_CHUNKED -- requirements
Module: adder_chunked

---
 rtl/adder_chunked_if.sv | 31 +++
 rtl/adder_chunked.sv | 142 ++++++++++++++
 tb/tb_adder_chunked.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_chunked_if.sv
// adder_chunked_if -- operand/result handshake bundle for adder_chunked.
//   in_valid/in_ready  : operand handshake (a, b, cin, sub)
//   out_valid/out_ready: result handshake (sum, cout, ovf)
//   busy               : adder is working or holding a result
// master = producer/consumer side, slave = the adder.
interface adder_chunked_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/adder_chunked.sv
// adder_chunked -- multi-cycle add/subtract, CHUNK bits per clock, LSB slice first.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : adder_chunked_if.slave (operand and result handshakes, busy)
// Subtraction is a + ~b + 1 (cin ignored); cout is the final carry (no-borrow
// when subtracting) and ovf the signed two's-complement overflow.
module adder_chunked #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input logic            clk,
  input logic            rst,
  adder_chunked_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;        // already inverted for subtraction
  logic              carry_r;    // carry into the next slice
  logic [IDXW-1:0]   idx_r;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              ovf_r;

  logic              in_ready_s;
  logic              accept_s;
  logic              last_s;
  logic [CHUNK-1:0]  a_slice_s;
  logic [CHUNK-1:0]  b_slice_s;
  logic [CHUNK-1:0]  slice_s;
  logic              carry_s;

  // Handshake qualifiers; in_ready is forced low while reset is asserted.
  always_comb begin
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    last_s     = 1'b0;
    if (state_r == IDLE && !rst) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = bus.in_valid && in_ready_s;
    last_s   = (idx_r == LAST_IDX);
  end

  // One slice of the add, with the carry rippled from the previous slice.
  always_comb begin
    a_slice_s = a_r[int'(idx_r)*CHUNK +: CHUNK];
    b_slice_s = b_r[int'(idx_r)*CHUNK +: CHUNK];
    {carry_s, slice_s} = {1'b0, a_slice_s} + {1'b0, b_slice_s} + (CHUNK+1)'(carry_r);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = CALC;
        else          state_nxt_s = IDLE;
      end
      CALC: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = CALC;
      end
      DONE: begin
        // No direct DONE->CALC path: an IDLE cycle always separates results.
        if (bus.out_ready) state_nxt_s = IDLE;
        else               state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, slice accumulation and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDXW{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ? 1'b1 : bus.cin;
            idx_r   <= {IDXW{1'b0}};
          end
        end
        CALC: begin
          sum_r[int'(idx_r)*CHUNK +: CHUNK] <= slice_s;
          carry_r <= carry_s;
          if (last_s) begin
            idx_r  <= {IDXW{1'b0}};
            cout_r <= carry_s;
            // slice_s MSB is the MSB of the final sum.
            ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (slice_s[CHUNK-1] != a_r[WIDTH-1]);
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        default: begin
          // DONE holds the result; it stays visible through IDLE as well.
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == DONE);
  assign bus.busy      = (state_r != IDLE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_adder_chunked.sv
// tb_adder_chunked -- randomized and directed checks of adder_chunked against
// a wide-arithmetic reference model. Two instances: 64/16 and 8/8.
module tb_adder_chunked;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  adder_chunked_if #(.WIDTH(64)) if64 ();
  adder_chunked_if #(.WIDTH(8))  if8  ();

  adder_chunked #(.WIDTH(64), .CHUNK(16)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));
  adder_chunked #(.WIDTH(8),  .CHUNK(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic; overflow from the sign-extended sum.
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub,
                       output logic [63:0] s, output logic co, output logic ov);
    logic [65:0] mask, aa, bb, full, ea, eb, r;
    logic        c;
    mask = (66'd1 << w) - 66'd1;
    aa   = {2'b00, a} & mask;
    bb   = (sub ? ~{2'b00, b} : {2'b00, b}) & mask;
    c    = sub ? 1'b1 : cin;
    full = aa + bb + {65'd0, c};
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    ea   = aa[w-1] ? (aa | ~mask) : aa;
    eb   = bb[w-1] ? (bb | ~mask) : bb;
    r    = ea + eb + {65'd0, c};
    ov   = (r[w] != r[w-1]);
  endtask

  function automatic logic get_ir(input int d);
    return (d == 0) ? if64.in_ready : if8.in_ready;
  endfunction
  function automatic logic get_ov(input int d);
    return (d == 0) ? if64.out_valid : if8.out_valid;
  endfunction
  function automatic logic [63:0] get_sum(input int d);
    return (d == 0) ? if64.sum : {56'd0, if8.sum};
  endfunction
  function automatic logic get_cout(input int d);
    return (d == 0) ? if64.cout : if8.cout;
  endfunction
  function automatic logic get_ovf(input int d);
    return (d == 0) ? if64.ovf : if8.ovf;
  endfunction
  function automatic logic get_busy(input int d);
    return (d == 0) ? if64.busy : if8.busy;
  endfunction

  task automatic set_in(input int d, input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub);
    if (d == 0) begin
      if64.in_valid = v; if64.a = a; if64.b = b; if64.cin = cin; if64.sub = sub;
    end else begin
      if8.in_valid = v; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = cin; if8.sub = sub;
    end
  endtask

  task automatic set_ordy(input int d, input logic r);
    if (d == 0) if64.out_ready = r;
    else        if8.out_ready = r;
  endtask

  // One full transaction: accept, latency, result, hold with stray inputs, release.
  task automatic run_op(input int d, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input int hold,
                        input logic chk_exp, input logic [63:0] esum,
                        input logic ecout, input logic eovf);
    logic [63:0] ms;
    logic        mc, mo;
    int          n;
    int          lat;
    int          w;
    w = (d == 0) ? 64 : 8;
    n = 0;
    while (!get_ir(d) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_eq("ready_wait", {63'd0, get_ir(d)}, 64'd1);
    set_in(d, 1'b1, a, b, cin, sub);
    set_ordy(d, 1'b0);
    @(posedge clk); #1;
    // Operand changes after acceptance must not reach the result.
    set_in(d, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    lat = 0;
    while (!get_ov(d) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check_eq("latency", 64'(lat), (d == 0) ? 64'd4 : 64'd1);
    model(w, a, b, cin, sub, ms, mc, mo);
    check_eq("sum", get_sum(d), ms);
    check_eq("cout", {63'd0, get_cout(d)}, {63'd0, mc});
    check_eq("ovf", {63'd0, get_ovf(d)}, {63'd0, mo});
    if (chk_exp) begin
      check_eq("sum_dir", get_sum(d), esum);
      check_eq("cout_dir", {63'd0, get_cout(d)}, {63'd0, ecout});
      check_eq("ovf_dir", {63'd0, get_ovf(d)}, {63'd0, eovf});
    end
    for (int i = 0; i < hold; i++) begin
      set_in(d, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
      check_eq("hold_valid", {63'd0, get_ov(d)}, 64'd1);
      check_eq("hold_sum", get_sum(d), ms);
      check_eq("hold_ready", {63'd0, get_ir(d)}, 64'd0);
    end
    set_in(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    set_ordy(d, 1'b1);
    @(posedge clk); #1;
    set_ordy(d, 1'b0);
    check_eq("released", {63'd0, get_ov(d)}, 64'd0);
    check_eq("idle_ready", {63'd0, get_ir(d)}, 64'd1);
    check_eq("idle_sum_held", get_sum(d), ms);
  endtask

  initial begin
    logic [63:0] ra, rb, ms;
    logic        mc, mo;
    int          gap;
    logic        seen;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_in(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    set_in(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {63'd0, if64.in_ready}, 64'd0);
    check_eq("rst_valid", {63'd0, if64.out_valid}, 64'd0);
    check_eq("rst_sum", if64.sum, 64'd0);
    check_eq("rst_cout", {63'd0, if64.cout}, 64'd0);
    check_eq("rst_ovf", {63'd0, if64.ovf}, 64'd0);
    check_eq("rst_busy", {63'd0, if64.busy}, 64'd0);
    check_eq("rst_ready8", {63'd0, if8.in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", {63'd0, if64.in_ready}, 64'd1);

    // Directed corner cases.
    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 0, 1'b1, 64'd0, 1'b1, 1'b0);
    run_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op(0, 64'd5, 64'd7, 1'b1, 1'b1, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op(0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 5, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op(1, 64'hF0, 64'h20, 1'b0, 1'b0, 0, 1'b1, 64'h10, 1'b1, 1'b0);

    // Reset during the second CALC cycle discards the operation.
    set_in(0, 1'b1, 64'h1234, 64'h5678, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    check_eq("mid_busy", {63'd0, if64.busy}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_valid", {63'd0, if64.out_valid}, 64'd0);
    check_eq("mid_rst_sum", if64.sum, 64'd0);
    check_eq("mid_rst_busy", {63'd0, if64.busy}, 64'd0);
    check_eq("mid_rst_ready", {63'd0, if64.in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check_eq("mid_post_ready", {63'd0, if64.in_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("no_result", {63'd0, if64.out_valid}, 64'd0);
    end
    run_op(0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 1, 1'b0, 64'd0, 1'b0, 1'b0);

    // Randomized operations on both widths.
    for (int i = 0; i < 36; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 7 == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
      if (i % 5 == 0) rb = 64'h8000_0000_0000_0000;
      run_op((i % 3 == 0) ? 1 : 0, ra, rb, 1'($urandom), 1'($urandom),
             $urandom_range(0, 2), 1'b0, 64'd0, 1'b0, 1'b0);
    end

    // Back-to-back on the 8-bit instance: in_ready low for exactly 2 cycles.
    set_in(1, 1'b1, 64'h3C, 64'h5A, 1'b1, 1'b0);
    set_ordy(1, 1'b1);
    model(8, 64'h3C, 64'h5A, 1'b1, 1'b0, ms, mc, mo);
    gap  = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (get_ir(1)) begin
        if (seen) check_eq("b2b_gap", 64'(gap), 64'd2);
        seen = 1'b1;
        gap  = 0;
      end else begin
        gap++;
      end
      if (get_ov(1)) check_eq("b2b_sum", get_sum(1), ms);
      @(posedge clk); #1;
    end
    set_in(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    set_ordy(1, 1'b0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
